// File: rtl/mod_n_updown_counter.sv
// Up/down counter with a run-time programmable modulus M, parallel load and
// count enable. Wrap-around and illegal modulus writes each give a one-cycle pulse.
module mod_n_updown_counter #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned N_DEFAULT = 10
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             mod_wr,
    input  logic [WIDTH-1:0] mod_in,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] mod_q,
    output logic             tc,
    output logic             err
);

    typedef enum logic [2:0] {
        OP_HOLD,
        OP_MOD_WR,
        OP_LOAD,
        OP_UP,
        OP_DOWN
    } op_e;

    localparam logic [WIDTH-1:0] MOD_RESET = WIDTH'(N_DEFAULT);
    localparam logic [WIDTH-1:0] MOD_MIN   = WIDTH'(2);

    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] modulus_q, modulus_d;
    logic             tc_q, tc_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] top_val;
    op_e              op;

    // modulus_q is never below 2, so M-1 never underflows
    assign top_val = modulus_q - 1'b1;

    always_comb begin
        op = OP_HOLD;
        if (mod_wr) begin
            op = OP_MOD_WR;
        end else if (load) begin
            op = OP_LOAD;
        end else if (en) begin
            op = up_dn ? OP_UP : OP_DOWN;
        end
    end

    always_comb begin
        count_d   = count_q;
        modulus_d = modulus_q;
        tc_d      = 1'b0;
        err_d     = 1'b0;
        unique case (op)
            OP_MOD_WR: begin
                if (mod_in >= MOD_MIN) begin
                    modulus_d = mod_in;
                    count_d   = '0;
                end else begin
                    err_d = 1'b1;
                end
            end
            OP_LOAD: begin
                count_d = (load_val <= top_val) ? load_val : top_val;
            end
            OP_UP: begin
                if (count_q == top_val) begin
                    count_d = '0;
                    tc_d    = 1'b1;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            OP_DOWN: begin
                if (count_q == '0) begin
                    count_d = top_val;
                    tc_d    = 1'b1;
                end else begin
                    count_d = count_q - 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            count_q   <= '0;
            modulus_q <= MOD_RESET;
            tc_q      <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            count_q   <= count_d;
            modulus_q <= modulus_d;
            tc_q      <= tc_d;
            err_q     <= err_d;
        end
    end

    assign out   = count_q;
    assign mod_q = modulus_q;
    assign tc    = tc_q;
    assign err   = err_q;

endmodule

// File: tb/tb_mod_n_updown_counter.sv
// Directed bench for mod_n_updown_counter (WIDTH = 4, N_DEFAULT = 10).
module tb_mod_n_updown_counter;

    localparam int unsigned WIDTH = 4;

    logic             clk = 1'b0;
    logic             rstn, en, up_dn, load, mod_wr;
    logic [WIDTH-1:0] load_val, mod_in;
    logic [WIDTH-1:0] out, mod_q;
    logic             tc, err;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    mod_n_updown_counter #(
        .WIDTH     (WIDTH),
        .N_DEFAULT (10)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .en       (en),
        .up_dn    (up_dn),
        .load     (load),
        .load_val (load_val),
        .mod_wr   (mod_wr),
        .mod_in   (mod_in),
        .out      (out),
        .mod_q    (mod_q),
        .tc       (tc),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag, input int e_out, input int e_mod,
                             input int e_tc, input int e_err);
        check({tag, ".out"}, int'(out), e_out);
        check({tag, ".mod"}, int'(mod_q), e_mod);
        check({tag, ".tc"}, int'(tc), e_tc);
        check({tag, ".err"}, int'(err), e_err);
    endtask

    // Inputs change 1 time unit after an edge; outputs are sampled there too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rstn = 1'b0; en = 1'b0; up_dn = 1'b1; load = 1'b0; mod_wr = 1'b0;
        load_val = '0; mod_in = '0;
    endtask

    task automatic do_reset();
        idle();
        rstn = 1'b1;
        step();
        rstn = 1'b0;
    endtask

    initial begin
        int e;
        idle();

        // 1: reset then count up with M = 10
        rstn = 1'b1;
        step();
        step();
        check_all("rst", 0, 10, 0, 0);
        rstn = 1'b0; en = 1'b1; up_dn = 1'b1;
        for (int i = 1; i <= 22; i++) begin
            step();
            e = i % 10;
            check("up.out", int'(out), e);
            check("up.tc", int'(tc), (e == 0) ? 1 : 0);
        end

        // 2: count down from reset
        do_reset();
        en = 1'b1; up_dn = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            step();
            e = (10 - (i % 10)) % 10;
            check("dn.out", int'(out), e);
            check("dn.tc", int'(tc), (e == 9) ? 1 : 0);
        end

        // 3: run-time modulus write and illegal modulus
        do_reset();
        en = 1'b1; up_dn = 1'b1;
        repeat (7) step();
        check("pre_mw.out", int'(out), 7);
        mod_wr = 1'b1; mod_in = 4'd5;
        step();
        check_all("mw5", 0, 5, 0, 0);
        mod_wr = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            step();
            e = i % 5;
            check("m5.out", int'(out), e);
            check("m5.tc", int'(tc), (e == 0) ? 1 : 0);
        end
        mod_wr = 1'b1; mod_in = 4'd1;
        step();
        check_all("mw1", 1, 5, 0, 1);
        mod_wr = 1'b1; mod_in = 4'd0; en = 1'b0;
        step();
        check_all("mw0", 1, 5, 0, 1);
        mod_wr = 1'b0;
        step();
        check_all("err_drop", 1, 5, 0, 0);

        // 4: load, saturation and priority
        do_reset();
        load = 1'b1; load_val = 4'd6;
        step();
        check_all("ld6", 6, 10, 0, 0);
        load_val = 4'd13;
        step();
        check_all("ld13", 9, 10, 0, 0);
        load_val = 4'd9; en = 1'b1; up_dn = 1'b1;
        step();
        check_all("ld9_en", 9, 10, 0, 0);
        load_val = 4'd3;
        step();
        check_all("ld3_en", 3, 10, 0, 0);
        mod_wr = 1'b1; mod_in = 4'd10; load_val = 4'd7;
        step();
        check_all("mw_ld", 0, 10, 0, 0);
        mod_wr = 1'b0; load = 1'b0; en = 1'b1; up_dn = 1'b0;
        step();
        check_all("dirchg_dn", 9, 10, 1, 0);
        up_dn = 1'b1;
        step();
        check_all("dirchg_up", 0, 10, 1, 0);

        // 5: reset in the middle of counting
        do_reset();
        mod_wr = 1'b1; mod_in = 4'd5;
        step();
        mod_wr = 1'b0; en = 1'b1; up_dn = 1'b1;
        repeat (3) step();
        check_all("pre_rst", 3, 5, 0, 0);
        rstn = 1'b1;
        step();
        check_all("mid_rst", 0, 10, 0, 0);
        rstn = 1'b0;
        step();
        check_all("post_rst", 1, 10, 0, 0);

        // 6: M = 2 toggling, then hold
        mod_wr = 1'b1; mod_in = 4'd2; en = 1'b1;
        step();
        check_all("mw2", 0, 2, 0, 0);
        mod_wr = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            step();
            e = i % 2;
            check("m2.out", int'(out), e);
            check("m2.tc", int'(tc), (e == 0) ? 1 : 0);
        end
        en = 1'b0;
        step();
        check_all("hold1", 0, 2, 0, 0);
        step();
        check_all("hold2", 0, 2, 0, 0);
        en = 1'b1; up_dn = 1'b0;
        step();
        check_all("m2_dn", 1, 2, 1, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
